mlp_activation_collector: RTL and testbench

Downstream neighbour of create_mlp_activations. Consumes its paired (timestamp, polarity) neighbourhood reads, two per beat. Converts each read into a signed time-decay feature relative to the triggering event's timestamp, and buffers one full patch. Streams the patch to the MLP input layer over a valid/ready interface, one feature per cycle.

---
 rtl/mlp_activation_collector.sv | 162 ++++++++++++++++
 tb/tb_mlp_activation_collector.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_activation_collector.sv
// Collects paired neighbourhood reads into a buffer of signed time-decay features and streams the patch out.
// Optional MLP_ACT_SELF_MASK_EN forces the centre entry (the event's own pixel) to zero.
module mlp_activation_collector #(
  parameter int TIMESTAMP_BITS = 16,
  parameter int POLARITY_BITS  = 2,
  parameter int NUM_ACT        = 25,
  parameter int WINDOW_LOG2    = 12,
  parameter int FEAT_BITS      = 8,
  parameter int IDX_BITS       = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TIMESTAMP_BITS-1:0] ref_timestamp,
  input  logic [TIMESTAMP_BITS-1:0] act_ts0,
  input  logic [POLARITY_BITS-1:0]  act_pol0,
  input  logic [TIMESTAMP_BITS-1:0] act_ts1,
  input  logic [POLARITY_BITS-1:0]  act_pol1,
  input  logic                      act_vld,
  input  logic                      act_done,
  output logic [FEAT_BITS-1:0]      feat_data,
  output logic [IDX_BITS-1:0]       feat_idx,
  output logic                      feat_vld,
  input  logic                      feat_rdy,
  output logic                      feat_last,
  output logic                      busy,
  output logic                      patch_done,
  output logic                      short_patch,
  output logic                      overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  localparam int SHIFT = WINDOW_LOG2 - FEAT_BITS + 1;
  localparam logic [TIMESTAMP_BITS:0] WINDOW  = {{TIMESTAMP_BITS{1'b0}}, 1'b1} << WINDOW_LOG2;
  localparam logic [TIMESTAMP_BITS:0] MAG_MAX = (TIMESTAMP_BITS+1)'((1 << (FEAT_BITS-1)) - 1);
  localparam logic [IDX_BITS:0]       NUM_W   = (IDX_BITS+1)'(NUM_ACT);
  localparam logic [IDX_BITS-1:0]     LAST_IDX = IDX_BITS'(NUM_ACT-1);
  localparam logic [POLARITY_BITS-1:0] POL_ON  = POLARITY_BITS'(1);
  localparam logic [POLARITY_BITS-1:0] POL_OFF = POLARITY_BITS'(2);
`ifdef MLP_ACT_SELF_MASK_EN
  localparam logic [IDX_BITS-1:0]     CENTRE  = IDX_BITS'(NUM_ACT/2);
`endif

  state_t                      state;
  logic [TIMESTAMP_BITS-1:0]   ref_q;
  logic [IDX_BITS:0]           wr_ptr;
  logic [IDX_BITS-1:0]         rd_ptr;
  logic [FEAT_BITS-1:0]        feat_buf [0:NUM_ACT-1];

  logic [FEAT_BITS-1:0]        feat0, feat1;
  logic [IDX_BITS:0]           wr_next1, wr_next2;
  logic [IDX_BITS-1:0]         idx0, idx1, rd_next;
  logic                        fill;

  // Linear decay over the window; the subtraction wraps so timestamps that rolled over still decay correctly.
  function automatic logic [FEAT_BITS-1:0] decay_feat(
    input logic [TIMESTAMP_BITS-1:0] ref_ts,
    input logic [TIMESTAMP_BITS-1:0] ts,
    input logic [POLARITY_BITS-1:0]  pol
  );
    logic [TIMESTAMP_BITS-1:0] dt;
    logic [TIMESTAMP_BITS:0]   mag;
    logic [FEAT_BITS-1:0]      mag_f;
    dt = ref_ts - ts;
    mag = (WINDOW - {1'b0, dt}) >> SHIFT;
    if (mag > MAG_MAX) mag = MAG_MAX;
    mag_f = mag[FEAT_BITS-1:0];
    decay_feat = '0;
    if ({1'b0, dt} < WINDOW) begin
      if (pol == POL_ON)       decay_feat = mag_f;
      else if (pol == POL_OFF) decay_feat = -mag_f;
    end
  endfunction

  always_comb begin
    wr_next1 = wr_ptr + (IDX_BITS+1)'(1);
    wr_next2 = wr_ptr + (IDX_BITS+1)'(2);
    idx0     = wr_ptr[IDX_BITS-1:0];
    idx1     = wr_next1[IDX_BITS-1:0];
    fill     = (wr_next2 >= NUM_W);
    rd_next  = rd_ptr + IDX_BITS'(1);
    feat0    = decay_feat(ref_q, act_ts0, act_pol0);
    feat1    = decay_feat(ref_q, act_ts1, act_pol1);
`ifdef MLP_ACT_SELF_MASK_EN
    if (idx0 == CENTRE) feat0 = '0;
    if (idx1 == CENTRE) feat1 = '0;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ref_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      feat_data   <= '0;
      feat_idx    <= '0;
      feat_vld    <= 1'b0;
      feat_last   <= 1'b0;
      patch_done  <= 1'b0;
      short_patch <= 1'b0;
      overflow    <= 1'b0;
      for (int i = 0; i < NUM_ACT; i++) feat_buf[i] <= '0;
    end else begin
      patch_done <= 1'b0;
      overflow   <= act_vld && (state != COLLECT);
      case (state)
        IDLE: begin
          if (start) begin
            ref_q       <= ref_timestamp;
            wr_ptr      <= '0;
            short_patch <= 1'b0;
            for (int i = 0; i < NUM_ACT; i++) feat_buf[i] <= '0;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (act_vld) begin
            feat_buf[idx0] <= feat0;
            if (wr_next1 < NUM_W) feat_buf[idx1] <= feat1;
            wr_ptr <= fill ? NUM_W : wr_next2;
          end
          // A beat that completes the patch wins over a simultaneous act_done, so it is not short.
          if (act_vld && fill) begin
            state <= DRAIN;
          end else if (act_done) begin
            state       <= DRAIN;
            short_patch <= 1'b1;
          end
        end
        DRAIN: begin
          if (!feat_vld) begin
            feat_vld  <= 1'b1;
            feat_data <= feat_buf[rd_ptr];
            feat_idx  <= rd_ptr;
            feat_last <= (rd_ptr == LAST_IDX);
          end else if (feat_rdy) begin
            if (feat_last) begin
              feat_vld   <= 1'b0;
              feat_data  <= '0;
              feat_idx   <= '0;
              feat_last  <= 1'b0;
              rd_ptr     <= '0;
              patch_done <= 1'b1;
              state      <= IDLE;
            end else begin
              rd_ptr    <= rd_next;
              feat_data <= feat_buf[rd_next];
              feat_idx  <= rd_next;
              feat_last <= (rd_next == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_activation_collector.sv
// Randomised bench for mlp_activation_collector against a patch-level reference model.
// Build with +define+MLP_ACT_SELF_MASK_EN to check the centre-masked variant.
module tb_mlp_activation_collector;

  localparam int TSB = 16;
  localparam int PB = 2;
  localparam int NUM_ACT = 25;
  localparam int WLOG = 12;
  localparam int FB = 8;
  localparam int IDX_BITS = 5;
  localparam int NBEATS = (NUM_ACT + 1) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [TSB-1:0] ref_timestamp = '0;
  logic [TSB-1:0] act_ts0 = '0, act_ts1 = '0;
  logic [PB-1:0] act_pol0 = '0, act_pol1 = '0;
  logic act_vld = 1'b0, act_done = 1'b0, feat_rdy = 1'b0;
  logic [FB-1:0] feat_data;
  logic [IDX_BITS-1:0] feat_idx;
  logic feat_vld, feat_last, busy, patch_done, short_patch, overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int b_ts0[NBEATS], b_pol0[NBEATS], b_ts1[NBEATS], b_pol1[NBEATS];
  int exp_feat[NUM_ACT];
  int cur_ref;

  mlp_activation_collector #(
    .TIMESTAMP_BITS(TSB), .POLARITY_BITS(PB), .NUM_ACT(NUM_ACT),
    .WINDOW_LOG2(WLOG), .FEAT_BITS(FB), .IDX_BITS(IDX_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ref_timestamp(ref_timestamp),
    .act_ts0(act_ts0), .act_pol0(act_pol0), .act_ts1(act_ts1), .act_pol1(act_pol1),
    .act_vld(act_vld), .act_done(act_done), .feat_data(feat_data), .feat_idx(feat_idx),
    .feat_vld(feat_vld), .feat_rdy(feat_rdy), .feat_last(feat_last), .busy(busy),
    .patch_done(patch_done), .short_patch(short_patch), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference feature: linear decay across the window, wrap-around age, sign from polarity.
  function automatic int model_feat(input int ref_ts, input int ts, input int pol);
    int dt, mag;
    dt = ((ref_ts - ts) % 65536 + 65536) % 65536;
    if (pol != 1 && pol != 2) return 0;
    if (dt >= (1 << WLOG)) return 0;
    mag = ((1 << WLOG) - dt) / (1 << (WLOG - FB + 1));
    if (mag > 127) mag = 127;
    return (pol == 1) ? mag : -mag;
  endfunction

  task automatic build_model(input int nb);
    for (int i = 0; i < NUM_ACT; i++) exp_feat[i] = 0;
    for (int b = 0; b < nb; b++) begin
      if (2*b < NUM_ACT)   exp_feat[2*b]   = model_feat(cur_ref, b_ts0[b], b_pol0[b]);
      if (2*b+1 < NUM_ACT) exp_feat[2*b+1] = model_feat(cur_ref, b_ts1[b], b_pol1[b]);
    end
`ifdef MLP_ACT_SELF_MASK_EN
    exp_feat[NUM_ACT/2] = 0;
`endif
  endtask

  task automatic clear_beats();
    for (int b = 0; b < NBEATS; b++) begin
      b_ts0[b] = 0; b_pol0[b] = 0; b_ts1[b] = 0; b_pol1[b] = 0;
    end
  endtask

  function automatic int near_ts(input int ref_ts);
    int off;
    off = int'($urandom % 5000);
    return ((ref_ts - off) % 65536 + 65536) % 65536;
  endfunction

  task automatic random_beats();
    for (int b = 0; b < NBEATS; b++) begin
      b_ts0[b]  = ($urandom % 4 == 0) ? int'($urandom % 65536) : near_ts(cur_ref);
      b_ts1[b]  = ($urandom % 4 == 0) ? int'($urandom % 65536) : near_ts(cur_ref);
      b_pol0[b] = int'($urandom % 4);
      b_pol1[b] = int'($urandom % 4);
    end
  endtask

  // Starts a patch and feeds nb beats; a short patch ends with act_done on the last beat or one cycle later.
  task automatic run_collect(input int nb, input bit done_same, input string name);
    start = 1'b1;
    ref_timestamp = TSB'(cur_ref);
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_after_start: got %0b expected 1", name, busy);
    end
    for (int b = 0; b < nb; b++) begin
      act_vld = 1'b1;
      act_ts0 = TSB'(b_ts0[b]); act_pol0 = PB'(b_pol0[b]);
      act_ts1 = TSB'(b_ts1[b]); act_pol1 = PB'(b_pol1[b]);
      act_done = (b == nb-1) && (nb < NBEATS) && done_same;
      tick();
      act_vld = 1'b0;
      act_done = 1'b0;
      tests_run++;
      if (overflow !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s overflow_in_collect beat %0d: got %0b expected 0", name, b, overflow);
      end
    end
    if (nb < NBEATS && !done_same) begin
      act_done = 1'b1;
      tick();
      act_done = 1'b0;
    end
    tests_run++;
    if (feat_vld !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s drain_entry: got vld=%0b busy=%0b expected vld=0 busy=1", name, feat_vld, busy);
    end
    tests_run++;
    if (short_patch !== (nb < NBEATS)) begin
      tests_failed++;
      $display("[TB] FAIL %s short_patch: got %0b expected %0b", name, short_patch, nb < NBEATS);
    end
    build_model(nb);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1.
  task automatic drain_check(input int mode, input string name);
    int got, pd, cyc;
    bit r, vld_before;
    got = 0; pd = 0; cyc = 0;
    while (got < NUM_ACT && cyc < 400) begin
      if (feat_vld === 1'b1) begin
        tests_run++;
        if (int'($signed(feat_data)) !== exp_feat[got] || feat_idx !== IDX_BITS'(got) ||
            feat_last !== (got == NUM_ACT-1)) begin
          tests_failed++;
          $display("[TB] FAIL %s feature %0d: got data=%0d idx=%0d last=%0b expected data=%0d idx=%0d last=%0b",
                   name, got, $signed(feat_data), feat_idx, feat_last, exp_feat[got], got, got == NUM_ACT-1);
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom % 2) == 1;
        default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      feat_rdy = r;
      vld_before = (feat_vld === 1'b1);
      tick();
      cyc++;
      if (patch_done === 1'b1) pd++;
      if (vld_before && r) got++;
    end
    feat_rdy = 1'b1;
    tick();
    if (patch_done === 1'b1) pd++;
    tests_run++;
    if (got != NUM_ACT) begin
      tests_failed++;
      $display("[TB] FAIL %s feature_count: got %0d expected %0d", name, got, NUM_ACT);
    end
    tests_run++;
    if (pd != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s patch_done_pulses: got %0d expected 1", name, pd);
    end
    tests_run++;
    if (feat_vld !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s idle_after_drain: got vld=%0b busy=%0b expected 0 0", name, feat_vld, busy);
    end
    feat_rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({feat_data, feat_idx, feat_vld, feat_last, busy, patch_done, short_patch, overflow} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s outputs: got data=%0h idx=%0d vld=%0b last=%0b busy=%0b done=%0b short=%0b ovf=%0b expected all 0",
               name, feat_data, feat_idx, feat_vld, feat_last, busy, patch_done, short_patch, overflow);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_beats();
    cur_ref = 100;
    b_ts0[0] = 100; b_pol0[0] = 1;
    b_ts1[0] = 64636; b_pol1[0] = 2;
    run_collect(NBEATS, 1'b0, "basic");
    drain_check(0, "basic");
  endtask

  task automatic test_wrap();
    clear_beats();
    cur_ref = 10;
    b_ts0[0] = 65000; b_pol0[0] = 1;
    b_ts1[0] = 61450; b_pol1[0] = 1;
    run_collect(NBEATS, 1'b0, "wrap");
    drain_check(0, "wrap");
  endtask

  task automatic test_full_beats();
    cur_ref = int'($urandom % 65536);
    random_beats();
    b_ts1[NBEATS-1] = cur_ref; b_pol1[NBEATS-1] = 1;
    run_collect(NBEATS, 1'b0, "full_beats");
    drain_check(0, "full_beats");
  endtask

  task automatic test_centre();
    clear_beats();
    cur_ref = int'($urandom % 65536);
    b_ts0[NUM_ACT/4] = cur_ref; b_pol0[NUM_ACT/4] = 1;
    b_ts1[NUM_ACT/4] = cur_ref; b_pol1[NUM_ACT/4] = 2;
    run_collect(NBEATS, 1'b0, "centre");
    drain_check(0, "centre");
  endtask

  task automatic test_random();
    int nb;
    for (int k = 0; k < 6; k++) begin
      cur_ref = int'($urandom % 65536);
      random_beats();
      nb = 1 + int'($urandom % NBEATS);
      run_collect(nb, ($urandom % 2) == 1, "random");
      drain_check(1, "random");
    end
  endtask

  task automatic test_short_patch();
    cur_ref = int'($urandom % 65536);
    clear_beats();
    for (int b = 0; b < 4; b++) begin
      b_ts0[b] = near_ts(cur_ref); b_pol0[b] = 1;
      b_ts1[b] = near_ts(cur_ref); b_pol1[b] = 2;
    end
    run_collect(4, 1'b0, "short_patch");
    drain_check(0, "short_patch");
  endtask

  task automatic test_stall();
    cur_ref = int'($urandom % 65536);
    random_beats();
    run_collect(NBEATS, 1'b0, "stall");
    start = 1'b1;
    ref_timestamp = TSB'($urandom);
    act_vld = 1'b1;
    tick();
    start = 1'b0;
    act_vld = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall overflow_pulse: got ovf=%0b busy=%0b expected 1 1", overflow, busy);
    end
    tick();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall overflow_clear: got %0b expected 0", overflow);
    end
    drain_check(2, "stall");
  endtask

  task automatic test_reset_mid();
    cur_ref = int'($urandom % 65536);
    random_beats();
    start = 1'b1;
    ref_timestamp = TSB'(cur_ref);
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      act_vld = 1'b1;
      act_ts0 = TSB'(b_ts0[b]); act_pol0 = PB'(b_pol0[b]);
      act_ts1 = TSB'(b_ts1[b]); act_pol1 = PB'(b_pol1[b]);
      tick();
    end
    act_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    rst_n = 1'b1;
    tick();
    cur_ref = int'($urandom % 65536);
    random_beats();
    run_collect(NBEATS, 1'b0, "after_reset");
    drain_check(1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_beats();
    test_centre();
    test_random();
    test_short_patch();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
